// File: rtl/llc_req_conflict_buffer_pkg.sv
// Shared types and default sizes for the LLC request conflict buffer.
// Optional stats outputs are enabled by LLC_CONFLICT_STATS_EN.
package llc_req_conflict_buffer_pkg;

    localparam int LLC_CONFLICT_DEPTH = 4;
    localparam int LLC_LINE_ADDR_W    = 26;
    localparam int LLC_SET_BITS       = 9;
    localparam int LLC_MSG_BITS       = 5;
    localparam int LLC_ID_BITS        = 6;

    typedef logic [LLC_LINE_ADDR_W-1:0] line_addr_t;
    typedef logic [LLC_SET_BITS-1:0]    llc_set_t;

    typedef struct packed {
        logic [LLC_MSG_BITS-1:0] msg;
        line_addr_t              addr;
        logic [LLC_ID_BITS-1:0]  id;
        logic                    eligible;
    } llc_req_entry_t;

endpackage

// File: rtl/llc_req_conflict_buffer_if.sv
// Upstream NoC request handshake into the LLC conflict buffer.
// Master drives valid/payload; slave returns ready.
interface llc_req_conflict_buffer_if
    import llc_req_conflict_buffer_pkg::*;
#(
    parameter int MSG_BITS    = LLC_MSG_BITS,
    parameter int LINE_ADDR_W = LLC_LINE_ADDR_W,
    parameter int ID_BITS     = LLC_ID_BITS
);
    logic                   llc_req_in_valid;
    logic                   llc_req_in_ready;
    logic [MSG_BITS-1:0]    req_in_msg;
    logic [LINE_ADDR_W-1:0] req_in_line_addr;
    logic [ID_BITS-1:0]     req_in_id;

    modport master (
        output llc_req_in_valid,
        output req_in_msg,
        output req_in_line_addr,
        output req_in_id,
        input  llc_req_in_ready
    );

    modport slave (
        input  llc_req_in_valid,
        input  req_in_msg,
        input  req_in_line_addr,
        input  req_in_id,
        output llc_req_in_ready
    );
endinterface

// File: rtl/llc_req_conflict_buffer_fifo.sv
// In-order backup FIFO for set-conflicted requests with per-entry replay eligibility.
// LLC_CONFLICT_STATS_EN adds push count and occupancy high-water outputs.
module llc_conflict_fifo
    import llc_req_conflict_buffer_pkg::*;
#(
    parameter int DEPTH       = LLC_CONFLICT_DEPTH,
    parameter int LINE_ADDR_W = LLC_LINE_ADDR_W,
    parameter int SET_BITS    = LLC_SET_BITS,
    parameter int MSG_BITS    = LLC_MSG_BITS,
    parameter int ID_BITS     = LLC_ID_BITS,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [MSG_BITS-1:0]    push_msg,
    input  logic [LINE_ADDR_W-1:0] push_addr,
    input  logic [ID_BITS-1:0]     push_id,
    input  logic                   release_en,
    input  logic [SET_BITS-1:0]    release_set,
    input  logic                   pop_req,
    output logic                   head_ready,
    output logic [MSG_BITS-1:0]    head_msg,
    output logic [LINE_ADDR_W-1:0] head_addr,
    output logic [ID_BITS-1:0]     head_id,
    output logic                   full,
    output logic                   overflow_err
`ifdef LLC_CONFLICT_STATS_EN
    ,
    output logic [15:0]            stat_push_cnt,
    output logic [CW-1:0]          stat_max_occ
`endif
);

    logic [MSG_BITS-1:0]    msg_q  [DEPTH];
    logic [LINE_ADDR_W-1:0] addr_q [DEPTH];
    logic [ID_BITS-1:0]     id_q   [DEPTH];
    logic [DEPTH-1:0]       elig_q;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic [AW-1:0] off [DEPTH];
    logic [DEPTH-1:0] rel_hit;
    logic pop;
    logic push_ok;
    logic push_elig;

    assign full       = count == CW'(DEPTH);
    assign head_ready = (count != '0) && elig_q[rd_ptr];
    assign head_msg   = msg_q[rd_ptr];
    assign head_addr  = addr_q[rd_ptr];
    assign head_id    = id_q[rd_ptr];

    assign pop       = pop_req && head_ready;
    assign push_ok   = push && (!full || pop);
    assign push_elig = release_en &&
                       (push_addr[SET_BITS-1:0] == release_set);
    assign count_nxt = count + CW'(push_ok) - CW'(pop);

    // An entry is live when its distance from the head is below count.
    always_comb begin
        rel_hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off[i] = AW'(i) - rd_ptr;
            rel_hit[i] = release_en &&
                         ({1'b0, off[i]} < count) &&
                         (addr_q[i][SET_BITS-1:0] == release_set);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            msg_q[wr_ptr]  <= push_msg;
            addr_q[wr_ptr] <= push_addr;
            id_q[wr_ptr]   <= push_id;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            elig_q       <= '0;
            overflow_err <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rel_hit[i]) elig_q[i] <= 1'b1;
            end
            if (push_ok) begin
                elig_q[wr_ptr] <= push_elig;
                wr_ptr         <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !push_ok) overflow_err <= 1'b1;
            count <= count_nxt;
        end
    end

`ifdef LLC_CONFLICT_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_push_cnt <= '0;
            stat_max_occ  <= '0;
        end else begin
            if (push_ok && stat_push_cnt != 16'hFFFF)
                stat_push_cnt <= stat_push_cnt + 16'd1;
            if (count_nxt > stat_max_occ)
                stat_max_occ <= count_nxt;
        end
    end
`endif

endmodule

// File: rtl/llc_req_conflict_buffer.sv
// LLC request input stage plus set-conflict backup/replay buffer.
// LLC_CONFLICT_STATS_EN adds stat_push_cnt / stat_max_occ outputs.
module llc_req_conflict_buffer
    import llc_req_conflict_buffer_pkg::*;
#(
    parameter int DEPTH       = LLC_CONFLICT_DEPTH,
    parameter int LINE_ADDR_W = LLC_LINE_ADDR_W,
    parameter int SET_BITS    = LLC_SET_BITS,
    parameter int MSG_BITS    = LLC_MSG_BITS,
    parameter int ID_BITS     = LLC_ID_BITS
) (
    input  logic                   clk,
    input  logic                   rst,
    llc_req_conflict_buffer_if.slave req_in,
    output logic                   llc_req_in_valid_int,
    input  logic                   llc_req_in_ready_int,
    output logic                   set_conflict,
    input  logic                   set_req_from_conflict,
    output logic [MSG_BITS-1:0]    req_out_msg,
    output logic [LINE_ADDR_W-1:0] req_out_addr,
    output logic [ID_BITS-1:0]     req_out_id,
    input  logic                   conflict_push,
    input  logic [MSG_BITS-1:0]    conflict_msg,
    input  logic [LINE_ADDR_W-1:0] conflict_addr,
    input  logic [ID_BITS-1:0]     conflict_id,
    input  logic                   conflict_release,
    input  logic [SET_BITS-1:0]    release_set,
    output logic                   conflict_full,
    output logic                   overflow_err
`ifdef LLC_CONFLICT_STATS_EN
    ,
    output logic [15:0]            stat_push_cnt,
    output logic [$clog2(DEPTH):0] stat_max_occ
`endif
);

    logic                   stage_valid;
    logic [MSG_BITS-1:0]    stage_msg;
    logic [LINE_ADDR_W-1:0] stage_addr;
    logic [ID_BITS-1:0]     stage_id;
    logic [MSG_BITS-1:0]    head_msg;
    logic [LINE_ADDR_W-1:0] head_addr;
    logic [ID_BITS-1:0]     head_id;
    logic                   accept;

    assign req_in.llc_req_in_ready = !conflict_full &&
        (!stage_valid || llc_req_in_ready_int);
    assign accept = req_in.llc_req_in_valid && req_in.llc_req_in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_valid <= 1'b0;
            stage_msg   <= '0;
            stage_addr  <= '0;
            stage_id    <= '0;
        end else if (accept) begin
            stage_valid <= 1'b1;
            stage_msg   <= req_in.req_in_msg;
            stage_addr  <= req_in.req_in_line_addr;
            stage_id    <= req_in.req_in_id;
        end else if (llc_req_in_ready_int) begin
            stage_valid <= 1'b0;
        end
    end

    assign llc_req_in_valid_int = stage_valid;

    // Replay takes priority over the fresh stage request.
    assign req_out_msg  = set_conflict ? head_msg  : stage_msg;
    assign req_out_addr = set_conflict ? head_addr : stage_addr;
    assign req_out_id   = set_conflict ? head_id   : stage_id;

    llc_conflict_fifo #(
        .DEPTH       (DEPTH),
        .LINE_ADDR_W (LINE_ADDR_W),
        .SET_BITS    (SET_BITS),
        .MSG_BITS    (MSG_BITS),
        .ID_BITS     (ID_BITS)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push         (conflict_push),
        .push_msg     (conflict_msg),
        .push_addr    (conflict_addr),
        .push_id      (conflict_id),
        .release_en   (conflict_release),
        .release_set  (release_set),
        .pop_req      (set_req_from_conflict),
        .head_ready   (set_conflict),
        .head_msg     (head_msg),
        .head_addr    (head_addr),
        .head_id      (head_id),
        .full         (conflict_full),
        .overflow_err (overflow_err)
`ifdef LLC_CONFLICT_STATS_EN
        ,
        .stat_push_cnt (stat_push_cnt),
        .stat_max_occ  (stat_max_occ)
`endif
    );

endmodule

// File: tb/tb_llc_req_conflict_buffer.sv
// Directed plus random bench for llc_req_conflict_buffer against a queue model.
// Stats outputs are also checked when LLC_CONFLICT_STATS_EN is defined.
module tb_llc_req_conflict_buffer;

    localparam int DEPTH = 4;
    localparam int LAW   = 26;
    localparam int SB    = 9;
    localparam int MB    = 5;
    localparam int IB    = 6;

    logic clk = 1'b0;
    logic rst;
    logic valid_int, ready_int;
    logic set_conflict, set_req;
    logic [MB-1:0]  out_msg;
    logic [LAW-1:0] out_addr;
    logic [IB-1:0]  out_id;
    logic c_push;
    logic [MB-1:0]  c_msg;
    logic [LAW-1:0] c_addr;
    logic [IB-1:0]  c_id;
    logic c_rel;
    logic [SB-1:0]  rel_set;
    logic c_full, ovf;
`ifdef LLC_CONFLICT_STATS_EN
    logic [15:0] stat_push_cnt;
    logic [$clog2(DEPTH):0] stat_max_occ;
    int m_pushes, m_max;
`endif

    int errors = 0;
    int checks = 0;

    llc_req_conflict_buffer_if #(
        .MSG_BITS(MB), .LINE_ADDR_W(LAW), .ID_BITS(IB)
    ) req_in ();

    llc_req_conflict_buffer #(
        .DEPTH(DEPTH), .LINE_ADDR_W(LAW), .SET_BITS(SB),
        .MSG_BITS(MB), .ID_BITS(IB)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .req_in                (req_in),
        .llc_req_in_valid_int  (valid_int),
        .llc_req_in_ready_int  (ready_int),
        .set_conflict          (set_conflict),
        .set_req_from_conflict (set_req),
        .req_out_msg           (out_msg),
        .req_out_addr          (out_addr),
        .req_out_id            (out_id),
        .conflict_push         (c_push),
        .conflict_msg          (c_msg),
        .conflict_addr         (c_addr),
        .conflict_id           (c_id),
        .conflict_release      (c_rel),
        .release_set           (rel_set),
        .conflict_full         (c_full),
        .overflow_err          (ovf)
`ifdef LLC_CONFLICT_STATS_EN
        ,
        .stat_push_cnt         (stat_push_cnt),
        .stat_max_occ          (stat_max_occ)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [MB-1:0]  msg;
        logic [LAW-1:0] addr;
        logic [IB-1:0]  id;
        bit             elig;
    } ent_t;

    ent_t q[$];
    bit m_sv, m_ovf;
    logic [MB-1:0]  m_smsg;
    logic [LAW-1:0] m_saddr;
    logic [IB-1:0]  m_sid;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_sc();
        return q.size() != 0 && q[0].elig;
    endfunction

    function automatic bit m_full();
        return q.size() == DEPTH;
    endfunction

    function automatic bit m_ready();
        return !m_full() && (!m_sv || ready_int);
    endfunction

    task automatic compare_all();
        ent_t h;
        bit sc;
        sc = m_sc();
        if (sc) h = q[0];
        else begin
            h.msg = m_smsg; h.addr = m_saddr; h.id = m_sid;
        end
        chk("ready", req_in.llc_req_in_ready, m_ready());
        chk("valid_int", valid_int, m_sv);
        chk("set_conflict", set_conflict, sc);
        chk("out_msg", out_msg, h.msg);
        chk("out_addr", out_addr, h.addr);
        chk("out_id", out_id, h.id);
        chk("full", c_full, m_full());
        chk("overflow", ovf, m_ovf);
`ifdef LLC_CONFLICT_STATS_EN
        chk("stat_push", stat_push_cnt, m_pushes);
        chk("stat_max", stat_max_occ, m_max);
`endif
    endtask

    task automatic model_update();
        ent_t e;
        ent_t t;
        bit pop, rdy;
        if (rst) begin
            q.delete();
            m_sv = 0; m_ovf = 0;
            m_smsg = '0; m_saddr = '0; m_sid = '0;
`ifdef LLC_CONFLICT_STATS_EN
            m_pushes = 0; m_max = 0;
`endif
            return;
        end
        pop = set_req && m_sc();
        rdy = m_ready();
        if (c_rel) begin
            foreach (q[i]) begin
                t = q[i];
                if (t.addr[SB-1:0] == rel_set) t.elig = 1;
                q[i] = t;
            end
        end
        if (pop) void'(q.pop_front());
        if (c_push) begin
            e.msg = c_msg; e.addr = c_addr; e.id = c_id;
            e.elig = c_rel && (c_addr[SB-1:0] == rel_set);
            if (q.size() < DEPTH) begin
                q.push_back(e);
`ifdef LLC_CONFLICT_STATS_EN
                if (m_pushes < 65535) m_pushes++;
`endif
            end else m_ovf = 1;
        end
`ifdef LLC_CONFLICT_STATS_EN
        if (q.size() > m_max) m_max = q.size();
`endif
        if (req_in.llc_req_in_valid && rdy) begin
            m_sv = 1;
            m_smsg = req_in.req_in_msg;
            m_saddr = req_in.req_in_line_addr;
            m_sid = req_in.req_in_id;
        end else if (ready_int) m_sv = 0;
    endtask

    task automatic step();
        #1;
        compare_all();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 0;
        req_in.llc_req_in_valid = 0;
        req_in.req_in_msg = '0;
        req_in.req_in_line_addr = '0;
        req_in.req_in_id = '0;
        ready_int = 0; set_req = 0;
        c_push = 0; c_msg = '0; c_addr = '0; c_id = '0;
        c_rel = 0; rel_set = '0;
    endtask

    task automatic do_push(logic [LAW-1:0] a);
        c_push = 1; c_addr = a;
        c_msg = MB'(a + 3); c_id = IB'(a + 7);
    endtask

    initial begin
        @(negedge clk);
        idle();
        rst = 1;
        step();
        rst = 0;
        #1;
        chk("rst_valid_int", valid_int, 1'b0);
        chk("rst_set_conflict", set_conflict, 1'b0);
        chk("rst_full", c_full, 1'b0);
        chk("rst_ready", req_in.llc_req_in_ready, 1'b1);
        chk("rst_out_addr", out_addr, 26'h0);
        chk("rst_overflow", ovf, 1'b0);

        req_in.llc_req_in_valid = 1;
        req_in.req_in_line_addr = 26'h0000123;
        req_in.req_in_msg = 5'h4;
        req_in.req_in_id = 6'h11;
        ready_int = 1;
        step();
        req_in.llc_req_in_valid = 0;
        chk("p1_valid_int", valid_int, 1'b1);
        chk("p1_addr", out_addr, 26'h0000123);
        step();
        chk("p1_drain", valid_int, 1'b0);
        idle();

        do_push(26'h0000205);
        step();
        c_push = 0;
        chk("p2_blocked", set_conflict, 1'b0);
        c_rel = 1; rel_set = 9'h005;
        step();
        c_rel = 0;
        chk("p2_replay", set_conflict, 1'b1);
        chk("p2_addr", out_addr, 26'h0000205);
        set_req = 1;
        step();
        set_req = 0;
        chk("p2_empty", set_conflict, 1'b0);

        do_push(26'h0000001);
        step();
        do_push(26'h0000002);
        step();
        c_push = 0;
        c_rel = 1; rel_set = 9'h002;
        step();
        chk("p3_head_block", set_conflict, 1'b0);
        rel_set = 9'h001;
        step();
        c_rel = 0;
        chk("p3_first", out_addr, 26'h0000001);
        set_req = 1;
        step();
        chk("p3_second", out_addr, 26'h0000002);
        chk("p3_second_sc", set_conflict, 1'b1);
        step();
        set_req = 0;
        chk("p3_done", set_conflict, 1'b0);

        req_in.llc_req_in_valid = 1;
        req_in.req_in_line_addr = 26'h0000321;
        step();
        req_in.llc_req_in_valid = 0;
        for (int i = 0; i < DEPTH; i++) begin
            do_push(LAW'(26'h10 + i));
            step();
        end
        ready_int = 1;
        #1;
        chk("p4_full", c_full, 1'b1);
        chk("p4_ready", req_in.llc_req_in_ready, 1'b0);
        ready_int = 0;
        do_push(26'h0000014);
        step();
        c_push = 0;
        chk("p4_overflow", ovf, 1'b1);
        chk("p4_still_full", c_full, 1'b1);
        c_rel = 1; rel_set = 9'h010;
        step();
        c_rel = 0;
        do_push(26'h0000015);
        set_req = 1;
        step();
        c_push = 0; set_req = 0;
        chk("p4_pushpop_full", c_full, 1'b1);

        rst = 1;
        step();
        rst = 0;
        chk("p6_valid_int", valid_int, 1'b0);
        chk("p6_sc", set_conflict, 1'b0);
        chk("p6_full", c_full, 1'b0);
        chk("p6_overflow", ovf, 1'b0);

        do_push(26'h0000077);
        c_rel = 1; rel_set = 9'h077;
        step();
        idle();
        chk("p5_same_cycle", set_conflict, 1'b1);
        chk("p5_addr", out_addr, 26'h0000077);
        set_req = 1;
        step();
        set_req = 0;

        for (int n = 0; n < 800; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            req_in.llc_req_in_valid = $urandom_range(0, 1) == 1;
            req_in.req_in_msg = MB'($urandom);
            req_in.req_in_line_addr = LAW'($urandom);
            req_in.req_in_id = IB'($urandom);
            ready_int = $urandom_range(0, 1) == 1;
            set_req = $urandom_range(0, 9) < 4;
            c_push = $urandom_range(0, 9) < 4;
            c_msg = MB'($urandom);
            c_addr = (LAW'($urandom) & ~LAW'(9'h1FF))
                   | LAW'($urandom_range(0, 3));
            c_id = IB'($urandom);
            c_rel = $urandom_range(0, 9) < 3;
            rel_set = SB'($urandom_range(0, 3));
            step();
        end
        idle();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
